// File: rtl/filter_pkg.sv
// Shared sizing helpers for the polyphase transmit filter: default geometry
// and the accumulator/rounding widths derived from it.
package filter_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int NB_INPUT_DEF   = 8;
    localparam int NBF_INPUT_DEF  = 7;
    localparam int NB_OUTPUT_DEF  = 8;
    localparam int NBF_OUTPUT_DEF = 7;
    localparam int NB_COEFF_DEF   = 8;
    localparam int NBF_COEFF_DEF  = 7;
    localparam int OV_SAMP_DEF    = 4;
    localparam int N_BAUD_DEF     = 6;
    localparam int N_CH_DEF       = 2;

    localparam int N_COEF  = N_BAUD_DEF * OV_SAMP_DEF;
    localparam int NBF_ACC = NBF_INPUT_DEF + NBF_COEFF_DEF;
    localparam int NB_ACC  = NB_INPUT_DEF + NB_COEFF_DEF + clog2(N_BAUD_DEF);
    localparam int SHIFT   = NBF_ACC - NBF_OUTPUT_DEF;

endpackage

// File: rtl/polyphase_fir_ds_round_sat.sv
// Accumulator-to-output conversion: arithmetic shift with round-half-up,
// then clamp to the signed output range.
module round_sat #(
    parameter int NB_IN  = 19,
    parameter int NB_OUT = 8,
    parameter int SHIFT  = 7
) (
    input  logic signed [NB_IN-1:0]  i_data,
    output logic signed [NB_OUT-1:0] o_data
);

    // One guard bit so the rounding constant can never wrap the accumulator.
    localparam logic signed [NB_IN:0] HALF  = (NB_IN+1)'((64'(1) << SHIFT) >> 1);
    localparam logic signed [NB_IN:0] MAX_V = (NB_IN+1)'((64'(1) << (NB_OUT-1)) - 64'(1));
    localparam logic signed [NB_IN:0] MIN_V = ~MAX_V;

    function automatic logic signed [NB_IN:0] f_round(input logic signed [NB_IN-1:0] v);
        logic signed [NB_IN:0] ext;
        ext = {v[NB_IN-1], v};
        return (ext + HALF) >>> SHIFT;
    endfunction

    function automatic logic signed [NB_OUT-1:0] f_sat(input logic signed [NB_IN:0] v);
        if (v > MAX_V) return MAX_V[NB_OUT-1:0];
        if (v < MIN_V) return MIN_V[NB_OUT-1:0];
        return v[NB_OUT-1:0];
    endfunction

    assign o_data = f_sat(f_round(i_data));

endmodule

// File: rtl/polyphase_fir_ds.sv
// Multi-channel polyphase pulse-shaping filter: one symbol per OV_SAMP clocks in,
// oversampled stream out every clock, plus a phase-selected symbol-rate stream.
module polyphase_fir_ds
    import filter_pkg::*;
#(
    parameter int NB_INPUT   = NB_INPUT_DEF,
    parameter int NBF_INPUT  = NBF_INPUT_DEF,
    parameter int NB_OUTPUT  = NB_OUTPUT_DEF,
    parameter int NBF_OUTPUT = NBF_OUTPUT_DEF,
    parameter int NB_COEFF   = NB_COEFF_DEF,
    parameter int NBF_COEFF  = NBF_COEFF_DEF,
    parameter int OV_SAMP    = OV_SAMP_DEF,
    parameter int N_BAUD     = N_BAUD_DEF,
    parameter int N_CH       = N_CH_DEF
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      i_enable,
    input  logic [clog2(OV_SAMP)-1:0]                 i_phase,
    input  logic [N_CH*NB_INPUT-1:0]                  i_symbol,
    output logic                                      o_sym_tick,
    input  logic                                      i_coeff_we,
    input  logic [clog2(N_BAUD*OV_SAMP)-1:0]          i_coeff_addr,
    input  logic signed [NB_COEFF-1:0]                i_coeff_data,
    output logic [N_CH*NB_OUTPUT-1:0]                 o_filt,
    output logic                                      o_filt_valid,
    output logic [N_CH*NB_OUTPUT-1:0]                 o_ds,
    output logic                                      o_ds_valid
);

    localparam int N_TAPS   = N_BAUD * OV_SAMP;
    localparam int ACC_W    = NB_INPUT + NB_COEFF + clog2(N_BAUD);
    localparam int RS_SHIFT = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;
    localparam int PH_W     = clog2(OV_SAMP);
    localparam int ADDR_W   = clog2(N_TAPS);

    logic [PH_W-1:0]             cnt_p0;
    logic [PH_W-1:0]             ph_p0;
    logic [PH_W-1:0]             ph_sel;
    logic                        sym_tick;
    logic signed [NB_COEFF-1:0]  coef [N_TAPS];
    logic signed [NB_INPUT-1:0]  dline_p0 [N_CH][N_BAUD];
    logic [N_CH*NB_OUTPUT-1:0]   y_p0;
    logic [N_CH*NB_OUTPUT-1:0]   filt_p1;
    logic [N_CH*NB_OUTPUT-1:0]   ds_p1;
    logic                        vld_p1;
    logic                        ds_vld_p1;

    assign sym_tick   = i_enable && (cnt_p0 == '0);
    assign o_sym_tick = sym_tick;

    // Stage p0: phase counter, delay lines and coefficient bank.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_p0 <= '0;
            ph_p0  <= PH_W'(OV_SAMP - 1);
            ph_sel <= '0;
        end else if (i_enable) begin
            cnt_p0 <= cnt_p0 + PH_W'(1);
            ph_p0  <= cnt_p0;
            if (sym_tick) ph_sel <= i_phase;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int ch = 0; ch < N_CH; ch++)
                for (int k = 0; k < N_BAUD; k++)
                    dline_p0[ch][k] <= '0;
        end else if (sym_tick) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                dline_p0[ch][0] <= i_symbol[ch*NB_INPUT +: NB_INPUT];
                for (int k = 1; k < N_BAUD; k++)
                    dline_p0[ch][k] <= dline_p0[ch][k-1];
            end
        end
    end

    // Writes are only accepted while the filter is frozen, so the MAC never sees a half-loaded set.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int t = 0; t < N_TAPS; t++) coef[t] <= '0;
        end else if (i_coeff_we && !i_enable && (32'(i_coeff_addr) < N_TAPS)) begin
            coef[i_coeff_addr] <= i_coeff_data;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] prod;
        logic [ADDR_W-1:0]       idx;

        always_comb begin
            acc  = '0;
            prod = '0;
            idx  = '0;
            for (int k = 0; k < N_BAUD; k++) begin
                idx  = ADDR_W'(k*OV_SAMP + int'(ph_p0));
                prod = dline_p0[ch][k] * coef[idx];
                acc  = acc + prod;
            end
        end

        round_sat #(
            .NB_IN  (ACC_W),
            .NB_OUT (NB_OUTPUT),
            .SHIFT  (RS_SHIFT)
        ) u_round_sat (
            .i_data (acc),
            .o_data (y_p0[ch*NB_OUTPUT +: NB_OUTPUT])
        );
    end

    // Stage p1: registered oversampled output and phase-selected downsample.
    always_ff @(posedge clock) begin
        if (!reset) begin
            filt_p1   <= '0;
            ds_p1     <= '0;
            vld_p1    <= 1'b0;
            ds_vld_p1 <= 1'b0;
        end else begin
            vld_p1    <= i_enable;
            ds_vld_p1 <= i_enable && (ph_p0 == ph_sel);
            if (i_enable) begin
                filt_p1 <= y_p0;
                if (ph_p0 == ph_sel) ds_p1 <= y_p0;
            end
        end
    end

    assign o_filt       = filt_p1;
    assign o_filt_valid = vld_p1;
    assign o_ds         = ds_p1;
    assign o_ds_valid   = ds_vld_p1;

endmodule

// File: tb/tb_polyphase_fir_ds.sv
// Directed bench for polyphase_fir_ds at default geometry (2 ch, OV=4, 6 baud).
module tb_polyphase_fir_ds;
    import filter_pkg::*;

    localparam int PH_W   = clog2(OV_SAMP_DEF);
    localparam int ADDR_W = clog2(N_COEF);

    logic              clock = 1'b0;
    logic              reset;
    logic              i_enable;
    logic [PH_W-1:0]   i_phase;
    logic [15:0]       i_symbol;
    logic              o_sym_tick;
    logic              i_coeff_we;
    logic [ADDR_W-1:0] i_coeff_addr;
    logic [7:0]        i_coeff_data;
    logic [15:0]       o_filt;
    logic              o_filt_valid;
    logic [15:0]       o_ds;
    logic              o_ds_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ds_tab [4];

    always #5 clock = ~clock;

    polyphase_fir_ds dut (
        .clock        (clock),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_phase      (i_phase),
        .i_symbol     (i_symbol),
        .o_sym_tick   (o_sym_tick),
        .i_coeff_we   (i_coeff_we),
        .i_coeff_addr (i_coeff_addr),
        .i_coeff_data (i_coeff_data),
        .o_filt       (o_filt),
        .o_filt_valid (o_filt_valid),
        .o_ds         (o_ds),
        .o_ds_valid   (o_ds_valid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_coef(input int addr, input logic [7:0] data);
        i_enable     = 1'b0;
        i_coeff_we   = 1'b1;
        i_coeff_addr = ADDR_W'(addr);
        i_coeff_data = data;
        step();
        i_coeff_we   = 1'b0;
    endtask

    // Expects c==0 and a flushed delay line; leaves the same state behind (28 edges).
    task automatic run_impulse(input string tag);
        logic [15:0] exp;
        i_phase  = '0;
        i_symbol = 16'h007F;
        i_enable = 1'b1;
        for (int n = 0; n < 28; n++) begin
            step();
            if (n == 0) i_symbol = 16'h0000;
            exp = (n >= 1 && n <= 4) ? 16'h0040 : 16'h0000;
            check_eq(tag, {o_filt_valid, o_sym_tick, o_filt}, {1'b1, ((n+1) % 4 == 0), exp});
        end
        i_enable = 1'b0;
    endtask

    initial begin
        int  m_c, m_p, m_ph, pre_p;
        bit  ev, tk;

        ds_tab[0] = 16'hF010;
        ds_tab[1] = 16'hE020;
        ds_tab[2] = 16'hD030;
        ds_tab[3] = 16'hC140;

        reset = 1'b0; i_enable = 1'b0; i_phase = '0; i_symbol = '0;
        i_coeff_we = 1'b0; i_coeff_addr = '0; i_coeff_data = '0;

        // Reset held with random inputs
        for (int n = 0; n < 10; n++) begin
            i_enable     = 1'($urandom);
            i_coeff_we   = 1'($urandom);
            i_coeff_addr = ADDR_W'($urandom);
            i_coeff_data = 8'($urandom);
            i_symbol     = 16'($urandom);
            i_phase      = PH_W'($urandom);
            step();
            check_eq("reset_hold", {o_filt, o_ds, o_filt_valid, o_ds_valid}, 64'd0);
        end
        reset = 1'b1; i_enable = 1'b0; i_coeff_we = 1'b0; i_symbol = '0; i_phase = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("idle", {o_filt, o_ds, o_filt_valid, o_ds_valid, o_sym_tick}, 64'd0);
        end

        // Impulse response
        for (int t = 0; t < 4; t++) wr_coef(t, 8'h40);
        run_impulse("impulse");

        // Write guard: enabled write and out-of-range write are both dropped
        i_enable = 1'b1; i_coeff_we = 1'b1; i_coeff_addr = '0; i_coeff_data = 8'h7F; i_symbol = '0;
        for (int n = 0; n < 4; n++) step();
        i_coeff_we = 1'b0; i_enable = 1'b0;
        wr_coef(N_COEF, 8'h7F);
        run_impulse("guard_impulse");

        // Downsampling with a mid-symbol phase change
        wr_coef(0, 8'h10); wr_coef(1, 8'h20); wr_coef(2, 8'h30); wr_coef(3, 8'h40);
        m_c = 0; m_p = 3; m_ph = 0;
        i_phase = 2'd2; i_symbol = 16'h817F; i_enable = 1'b1;
        for (int n = 0; n < 28; n++) begin
            if (n == 17) i_phase = 2'd1;
            ev = (m_p == m_ph);
            tk = (m_c == 0);
            pre_p = m_p;
            step();
            if (tk) m_ph = int'(i_phase);
            m_p = m_c;
            m_c = (m_c + 1) % 4;
            check_eq("ds_valid", {63'd0, o_ds_valid}, {63'd0, ev});
            if (ev) check_eq("ds_value", {48'd0, o_ds}, {48'd0, ds_tab[pre_p]});
        end
        i_enable = 1'b0;

        // Saturation, both polarities on both channels
        for (int t = 0; t < N_COEF; t++) wr_coef(t, 8'h7F);
        i_symbol = 16'h807F; i_enable = 1'b1;
        for (int n = 0; n < 32; n++) begin
            step();
            if (n >= 28) check_eq("sat_pos_neg", {48'd0, o_filt}, 64'h807F);
        end
        i_symbol = 16'h7F80;
        for (int n = 0; n < 32; n++) begin
            step();
            if (n >= 28) check_eq("sat_neg_pos", {48'd0, o_filt}, 64'h7F80);
        end

        // Reset in the middle of a symbol (c==2)
        step(); step();
        reset = 1'b0;
        step();
        check_eq("mid_reset", {o_filt, o_ds, o_filt_valid, o_ds_valid}, 64'd0);
        reset = 1'b1;
        check_eq("tick_after_reset", {63'd0, o_sym_tick}, 64'd1);
        i_symbol = 16'h7F7F;
        for (int n = 0; n < 8; n++) begin
            step();
            check_eq("coef_cleared", {o_filt_valid, o_sym_tick, o_filt},
                     {1'b1, ((n+1) % 4 == 0), 16'h0000});
        end
        i_enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
